// File: rtl/alu_mem_pkg.sv
// Shared encodings for the execute/memory stage: alu_op codes, opcodes, ALU selects.
// Latency: n/a (definitions only). Backpressure: n/a.
// Imported by alu_mem_stage and alu_mem_dmem.
package alu_mem_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    localparam logic [1:0] ALUOP_R    = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_LDST = 2'b10;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_INV = 3'b010,
        ALU_SHL = 3'b011,
        ALU_SHR = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_SLT = 3'b111
    } alu_sel_e;

endpackage

// File: rtl/alu_mem_dmem.sv
// Data RAM: synchronous write, synchronous clear on rst, combinational gated read.
// Latency: read 0 cycles, write visible after the next posedge. Backpressure: none.
// Reset clears every word and drops the write presented in the same cycle.
module alu_mem_dmem
    import alu_mem_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int WORDS = DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem_q [WORDS];
    logic [DW-1:0] mem_d [WORDS];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[addr] = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = rd_en ? mem_q[addr] : '0;

endmodule

// File: rtl/alu_mem_stage.sv
// Execute/memory stage: ALU-select decode, 16-bit ALU with zero flag, data RAM addressed by the result.
// Latency: decode/ALU/read 0 cycles, write 1 cycle. Backpressure: none (single-cycle datapath).
// Optional ALU_FLAGS_EN adds neg_flag and carry_flag outputs.
module alu_mem_stage
    import alu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] write_data,
    output logic [2:0]        alu_cnt,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero_flag,
    output logic [DATA_W-1:0] mem_read_data
`ifdef ALU_FLAGS_EN
   ,output logic              neg_flag
   ,output logic              carry_flag
`endif
);

    localparam int                SHAMT_W   = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

    alu_sel_e alu_sel;

    always_comb begin
        alu_sel = ALU_ADD;
        case (alu_op)
            ALUOP_LDST: alu_sel = ALU_ADD;
            ALUOP_BR:   alu_sel = ALU_SUB;
            default: begin
                // ALUOP_R and the unused 2'b11 both take the function from the opcode
                case (opcode)
                    OP_ADD:  alu_sel = ALU_ADD;
                    OP_SUB:  alu_sel = ALU_SUB;
                    OP_INV:  alu_sel = ALU_INV;
                    OP_SHL:  alu_sel = ALU_SHL;
                    OP_SHR:  alu_sel = ALU_SHR;
                    OP_AND:  alu_sel = ALU_AND;
                    OP_OR:   alu_sel = ALU_OR;
                    OP_SLT:  alu_sel = ALU_SLT;
                    default: alu_sel = ALU_ADD;
                endcase
            end
        endcase
    end

    assign alu_cnt = alu_sel;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_ADD: alu_result = a + b;
            ALU_SUB: alu_result = a - b;
            ALU_INV: alu_result = ~a;
            ALU_SHL: alu_result = (b >= SHIFT_LIM) ? '0 : (a << b[SHAMT_W-1:0]);
            ALU_SHR: alu_result = (b >= SHIFT_LIM) ? '0 : (a >> b[SHAMT_W-1:0]);
            ALU_AND: alu_result = a & b;
            ALU_OR:  alu_result = a | b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, (a < b)};
            default: alu_result = '0;
        endcase
    end

    assign zero_flag = (alu_result == '0);

`ifdef ALU_FLAGS_EN
    // Unsigned wrap detection: a sum smaller than an addend carried out; a < b borrows.
    always_comb begin
        carry_flag = 1'b0;
        case (alu_sel)
            ALU_ADD: carry_flag = (alu_result < a);
            ALU_SUB: carry_flag = (a < b);
            default: carry_flag = 1'b0;
        endcase
    end

    assign neg_flag = alu_result[DATA_W-1];
`endif

    alu_mem_dmem #(
        .DW    (DATA_W),
        .AW    (ADDR_W),
        .WORDS (DEPTH)
    ) u_dmem (
        .clk    (clk),
        .rst    (rst),
        .addr   (alu_result[ADDR_W-1:0]),
        .wr_en  (mem_write),
        .wr_dat (write_data),
        .rd_en  (mem_read),
        .rd_dat (mem_read_data)
    );

endmodule

// File: tb/tb_alu_mem_stage.sv
// Directed vectors for alu_mem_stage; a driver queues hand-computed expectations, a monitor checks them.
module tb_alu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  alu_op;
    logic [3:0]  opcode;
    logic [15:0] a;
    logic [15:0] b;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] write_data;
    logic [2:0]  alu_cnt;
    logic [15:0] alu_result;
    logic        zero_flag;
    logic [15:0] mem_read_data;
`ifdef ALU_FLAGS_EN
    logic        neg_flag;
    logic        carry_flag;
`endif

    alu_mem_stage dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op        (alu_op),
        .opcode        (opcode),
        .a             (a),
        .b             (b),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .write_data    (write_data),
        .alu_cnt       (alu_cnt),
        .alu_result    (alu_result),
        .zero_flag     (zero_flag),
        .mem_read_data (mem_read_data)
`ifdef ALU_FLAGS_EN
       ,.neg_flag      (neg_flag)
       ,.carry_flag    (carry_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [2:0]  cnt;
        logic [15:0] res;
        logic        zero;
        logic [15:0] rd;
        logic        carry;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   vec_id     = 0;
    logic obs_vld    = 1'b0;

    task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s vec%0d: got %h, expected %h", name, id, act, req);
        end
    endtask

    // Monitor: outputs are combinational, sampled on the falling edge of each observed cycle.
    always @(negedge clk) begin
        if (obs_vld) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard_underflow: got output, expected nothing queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alu_cnt", e.id, {13'd0, alu_cnt}, {13'd0, e.cnt});
                chk("alu_result", e.id, alu_result, e.res);
                chk("zero_flag", e.id, {15'd0, zero_flag}, {15'd0, e.zero});
                chk("mem_read_data", e.id, mem_read_data, e.rd);
`ifdef ALU_FLAGS_EN
                chk("carry_flag", e.id, {15'd0, carry_flag}, {15'd0, e.carry});
                chk("neg_flag", e.id, {15'd0, neg_flag}, {15'd0, e.res[15]});
`endif
            end
        end
    end

    task automatic apply(input logic r, input logic [1:0] op, input logic [3:0] opc,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic mr, input logic mw, input logic [15:0] wd,
                         input logic [2:0] e_cnt, input logic [15:0] e_res, input logic e_zero,
                         input logic [15:0] e_rd, input logic e_carry);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; alu_op = op; opcode = opc; a = va; b = vb;
        mem_read = mr; mem_write = mw; write_data = wd;
        e.id = vec_id; e.cnt = e_cnt; e.res = e_res; e.zero = e_zero; e.rd = e_rd; e.carry = e_carry;
        exp_q.push_back(e);
        vec_id++;
        obs_vld = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_op = 2'b00; opcode = 4'd0; a = '0; b = '0;
        mem_read = 1'b0; mem_write = 1'b0; write_data = '0;
        repeat (2) @(posedge clk);

        // reset state: memory reads as zero
        apply(0, 2'b10, 4'h0, 16'h0000, 16'h0000, 1, 0, 16'h0, 3'd0, 16'h0000, 1, 16'h0000, 0);
        apply(0, 2'b10, 4'h0, 16'h0007, 16'h0000, 1, 0, 16'h0, 3'd0, 16'h0007, 0, 16'h0000, 0);
        // basic add / sub
        apply(0, 2'b00, 4'b0010, 16'd5, 16'd3, 0, 0, 16'h0, 3'd0, 16'd8, 0, 16'h0, 0);
        apply(0, 2'b01, 4'h0, 16'h1234, 16'h1234, 0, 0, 16'h0, 3'd1, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b01, 4'h0, 16'd2, 16'd3, 0, 0, 16'h0, 3'd1, 16'hFFFF, 0, 16'h0, 1);
        // opcode sweep, a=00F0 b=4
        apply(0, 2'b00, 4'b0011, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd1, 16'h00EC, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b0100, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd2, 16'hFF0F, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b0101, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd3, 16'h0F00, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b0110, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd4, 16'h000F, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b0111, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd5, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b00, 4'b1000, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd6, 16'h00F4, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b1001, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd7, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b00, 4'b1111, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd0, 16'h00F4, 0, 16'h0, 0);
        apply(0, 2'b11, 4'b0101, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd3, 16'h0F00, 0, 16'h0, 0);
        apply(0, 2'b10, 4'b1001, 16'h00F0, 16'd4, 0, 0, 16'h0, 3'd0, 16'h00F4, 0, 16'h0, 0);
        // shift limits and unsigned compare
        apply(0, 2'b00, 4'b0101, 16'h0001, 16'd16, 0, 0, 16'h0, 3'd3, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b00, 4'b0101, 16'h0001, 16'd15, 0, 0, 16'h0, 3'd3, 16'h8000, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b0110, 16'h8000, 16'd16, 0, 0, 16'h0, 3'd4, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b00, 4'b0110, 16'h8000, 16'd15, 0, 0, 16'h0, 3'd4, 16'h0001, 0, 16'h0, 0);
        apply(0, 2'b00, 4'b1001, 16'h8000, 16'd1, 0, 0, 16'h0, 3'd7, 16'h0000, 1, 16'h0, 0);
        apply(0, 2'b00, 4'b1001, 16'h0001, 16'h8000, 0, 0, 16'h0, 3'd7, 16'h0001, 0, 16'h0, 0);
        apply(0, 2'b10, 4'h0, 16'hFFFF, 16'd1, 0, 0, 16'h0, 3'd0, 16'h0000, 1, 16'h0, 1);
        // store then load; same-cycle read sees the old word
        apply(0, 2'b10, 4'h0, 16'd2, 16'd1, 1, 1, 16'hBEEF, 3'd0, 16'd3, 0, 16'h0000, 0);
        apply(0, 2'b10, 4'h0, 16'd2, 16'd1, 1, 0, 16'h0, 3'd0, 16'd3, 0, 16'hBEEF, 0);
        apply(0, 2'b10, 4'h0, 16'd10, 16'd1, 1, 0, 16'h0, 3'd0, 16'd11, 0, 16'hBEEF, 0);
        apply(0, 2'b10, 4'h0, 16'd10, 16'd1, 0, 0, 16'h0, 3'd0, 16'd11, 0, 16'h0000, 0);
        // fill all words, read back
        for (int i = 0; i < 8; i++) begin
            apply(0, 2'b10, 4'h0, 16'(i), 16'd0, 1, 1, 16'hA000 + 16'(i), 3'd0, 16'(i), (i == 0),
                  (i == 3) ? 16'hBEEF : 16'h0000, 0);
        end
        for (int i = 0; i < 8; i++) begin
            apply(0, 2'b10, 4'h0, 16'(i) + 16'd8, 16'd0, 1, 0, 16'h0, 3'd0, 16'(i) + 16'd8, 0,
                  16'hA000 + 16'(i), 0);
        end
        // reset with a write pending: old word still visible in that cycle, then everything cleared
        apply(1, 2'b10, 4'h0, 16'd5, 16'd0, 1, 1, 16'h1111, 3'd0, 16'd5, 0, 16'hA005, 0);
        for (int i = 0; i < 8; i++) begin
            apply(0, 2'b10, 4'h0, 16'(i), 16'd0, 1, 0, 16'h0, 3'd0, 16'(i), (i == 0), 16'h0000, 0);
        end
        apply(0, 2'b10, 4'h0, 16'd6, 16'd0, 1, 1, 16'h5A5A, 3'd0, 16'd6, 0, 16'h0000, 0);
        apply(0, 2'b10, 4'h0, 16'd14, 16'd0, 1, 0, 16'h0, 3'd0, 16'd14, 0, 16'h5A5A, 0);

        @(posedge clk);
        #1;
        obs_vld = 1'b0;
        mem_write = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
